// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner and the keypad matrix / key consumer.
// The master side is the scanner; the slave side is the keypad matrix and consumer.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output column,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  column,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column drive and detects single key closures.
// Each accepted press is debounced, and each release is debounced before scanning resumes.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] DB_FULL    = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Returns {exactly_one_low, index_of_low_bit}; ghosted or idle rows decode as invalid.
    function automatic logic [2:0] decode_row(input logic [3:0] r);
        logic [2:0] d;
        case (r)
            4'b1110: d = 3'b100;
            4'b1101: d = 3'b101;
            4'b1011: d = 3'b110;
            4'b0111: d = 3'b111;
            default: d = 3'b000;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] p;
        case (idx)
            2'd0:    p = 4'b1110;
            2'd1:    p = 4'b1101;
            2'd2:    p = 4'b1011;
            2'd3:    p = 4'b0111;
            default: p = 4'b1111;
        endcase
        return p;
    endfunction

    logic [3:0]    row_meta_r, row_sync_r;
    state_t        state_r, state_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [CW-1:0] db_cnt_r, db_cnt_s;
    logic [1:0]    col_idx_r, col_idx_s;
    logic [1:0]    row_idx_r, row_idx_s;
    logic [3:0]    row_pat_r, row_pat_s;
    logic [3:0]    column_r, column_s;
    logic [3:0]    key_code_r, key_code_s;
    logic          key_valid_r, key_valid_s;
    logic          key_held_r, key_held_s;
    logic [2:0]    row_dec_s;

    assign row_dec_s = decode_row(row_sync_r);
    assign column_s  = col_pattern(col_idx_s);

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= kp.row;
            row_sync_r <= row_meta_r;
        end
    end

    // Next-state and next-output logic for the scan/debounce FSM.
    always_comb begin
        state_s     = state_r;
        dwell_s     = dwell_r;
        db_cnt_s    = db_cnt_r;
        col_idx_s   = col_idx_r;
        row_idx_s   = row_idx_r;
        row_pat_s   = row_pat_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_s = {DW{1'b0}};
                    if (row_dec_s[2]) begin
                        row_pat_s = row_sync_r;
                        row_idx_s = row_dec_s[1:0];
                        db_cnt_s  = {CW{1'b0}};
                        state_s   = DEBOUNCE;
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end else begin
                    dwell_s = dwell_r + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (row_sync_r == row_pat_r) begin
                    if (db_cnt_r == DB_LAST) begin
                        state_s     = HELD;
                        db_cnt_s    = DB_FULL;
                        key_code_s  = {row_idx_r, col_idx_r};
                        key_valid_s = 1'b1;
                        key_held_s  = 1'b1;
                    end else begin
                        db_cnt_s = db_cnt_r + CW'(1);
                    end
                end else begin
                    state_s   = SCAN;
                    col_idx_s = col_idx_r + 2'd1;
                    dwell_s   = {DW{1'b0}};
                end
            end
            HELD: begin
                // Any other non-idle pattern is ignored until a full release is seen.
                if (row_sync_r == 4'b1111) begin
                    state_s  = RELEASE;
                    db_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE: begin
                if (row_sync_r == 4'b1111) begin
                    if (db_cnt_r == DB_LAST) begin
                        state_s    = SCAN;
                        key_held_s = 1'b0;
                        col_idx_s  = col_idx_r + 2'd1;
                        dwell_s    = {DW{1'b0}};
                        db_cnt_s   = DB_FULL;
                    end else begin
                        db_cnt_s = db_cnt_r + CW'(1);
                    end
                end else begin
                    state_s = HELD;
                end
            end
            default: begin
                state_s    = SCAN;
                dwell_s    = {DW{1'b0}};
                db_cnt_s   = {CW{1'b0}};
                col_idx_s  = 2'd0;
                key_held_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SCAN;
            dwell_r     <= {DW{1'b0}};
            db_cnt_r    <= {CW{1'b0}};
            col_idx_r   <= 2'd0;
            row_idx_r   <= 2'd0;
            row_pat_r   <= 4'b1111;
            column_r    <= 4'b1110;
            key_code_r  <= 4'b0000;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            dwell_r     <= dwell_s;
            db_cnt_r    <= db_cnt_s;
            col_idx_r   <= col_idx_s;
            row_idx_r   <= row_idx_s;
            row_pat_r   <= row_pat_s;
            column_r    <= column_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign kp.column    = column_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_CNT=8.
module tb_keypad_scanner;

    logic clk;
    logic rst;
    int   evals;
    int   fails;
    int   pulses;
    logic [3:0] rot [4];

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (kp.key_valid === 1'b1) pulses++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        kp.row = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset, then close row2 while column 1101 is driven; returns on the DEBOUNCE entry edge.
    task automatic press();
        do_reset();
        repeat (4) tick();
        kp.row = 4'b1011;
        repeat (4) tick();
    endtask

    initial begin
        evals  = 0;
        fails  = 0;
        pulses = 0;
        rot[0] = 4'b1110;
        rot[1] = 4'b1101;
        rot[2] = 4'b1011;
        rot[3] = 4'b0111;
        rst    = 1'b1;
        kp.row = 4'b1111;

        // Reset values
        do_reset();
        chk("rst_column", 8'(kp.column), 8'h0e);
        chk("rst_code", 8'(kp.key_code), 8'h00);
        chk("rst_valid", 8'(kp.key_valid), 8'h00);
        chk("rst_held", 8'(kp.key_held), 8'h00);

        // Idle scan: each pattern held 4 clocks
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("idle_column", 8'(kp.column), 8'(rot[(k / 4) % 4]));
        end
        chk("idle_no_valid", 8'(pulses), 8'h00);

        // Clean press on row2/col1, then release with bounce
        press();
        chk("press_freeze", 8'(kp.column), 8'h0d);
        pulses = 0;
        repeat (7) tick();
        chk("press_not_early", 8'(kp.key_valid), 8'h00);
        tick();
        chk("press_valid", 8'(kp.key_valid), 8'h01);
        chk("press_code", 8'(kp.key_code), 8'h09);
        chk("press_held", 8'(kp.key_held), 8'h01);
        tick();
        chk("press_pulse_end", 8'(kp.key_valid), 8'h00);
        chk("press_held_on", 8'(kp.key_held), 8'h01);
        chk("press_column_frozen", 8'(kp.column), 8'h0d);

        kp.row = 4'b1111;
        repeat (4) tick();
        kp.row = 4'b1011;
        repeat (2) tick();
        kp.row = 4'b1111;
        repeat (2) tick();
        chk("rel_bounce_held", 8'(kp.key_held), 8'h01);
        repeat (8) tick();
        chk("rel_held_last", 8'(kp.key_held), 8'h01);
        tick();
        chk("rel_held_fall", 8'(kp.key_held), 8'h00);
        chk("rel_next_column", 8'(kp.column), 8'h0b);
        chk("rel_code_kept", 8'(kp.key_code), 8'h09);
        chk("rel_one_pulse", 8'(pulses), 8'h01);

        // Press bounce: 3 clocks low then released
        press();
        pulses = 0;
        repeat (3) tick();
        kp.row = 4'b1111;
        repeat (2) tick();
        chk("pb_still_frozen", 8'(kp.column), 8'h0d);
        tick();
        chk("pb_resume", 8'(kp.column), 8'h0b);
        repeat (3) tick();
        chk("pb_fresh_dwell", 8'(kp.column), 8'h0b);
        tick();
        chk("pb_rotate", 8'(kp.column), 8'h07);
        chk("pb_no_valid", 8'(pulses), 8'h00);
        chk("pb_code_kept", 8'(kp.key_code), 8'h00);
        chk("pb_not_held", 8'(kp.key_held), 8'h00);

        // Ghosting: two rows low is never detected
        do_reset();
        kp.row = 4'b1001;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("ghost_column", 8'(kp.column), 8'(rot[(k / 4) % 4]));
        end
        chk("ghost_no_valid", 8'(pulses), 8'h00);

        // Reset mid-debounce aborts without a pulse
        press();
        repeat (4) tick();
        pulses = 0;
        rst    = 1'b1;
        kp.row = 4'b1111;
        tick();
        chk("rdb_column", 8'(kp.column), 8'h0e);
        rst = 1'b0;
        repeat (12) tick();
        chk("rdb_no_valid", 8'(pulses), 8'h00);
        chk("rdb_not_held", 8'(kp.key_held), 8'h00);

        // Reset while HELD
        press();
        repeat (9) tick();
        chk("rh_pre_code", 8'(kp.key_code), 8'h09);
        chk("rh_pre_held", 8'(kp.key_held), 8'h01);
        rst = 1'b1;
        tick();
        chk("rh_column", 8'(kp.column), 8'h0e);
        chk("rh_code", 8'(kp.key_code), 8'h00);
        chk("rh_held", 8'(kp.key_held), 8'h00);
        chk("rh_valid", 8'(kp.key_valid), 8'h00);
        rst    = 1'b0;
        kp.row = 4'b1111;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
